mips_multicycle_ctrl: RTL and testbench

Multi-cycle control sequencer for the MIPS datapath. It replaces the single-cycle combinational control unit with a Moore state machine that walks each instruction through fetch, decode, execute, memory and write-back. This lets the ALU and a single shared instruction/data memory be reused across cycles. It handshakes with memory through a request/ready pair that tolerates wait states and times out on a dead bus. It also keeps cycle and retired-instruction counters.

---
 rtl/mips_multicycle_ctrl.sv | 262 ++++++++++++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// mips_multicycle_ctrl
//
// Multi-cycle control sequencer for a MIPS datapath. A Moore state machine
// steps each instruction through fetch, decode, execute, memory and
// write-back. The ALU and one shared instruction/data memory are therefore
// reused across cycles. Memory accesses use a request/ready handshake that
// accepts wait states and gives up after MEM_TIMEOUT cycles without ready.
//
// Parameters
//   MEM_TIMEOUT  cycles without mem_ready in a memory state before bus_err
//                is raised (2..255)
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous, active-low reset
//   opcode       instruction[31:26] from the IR
//   zero         ALU zero flag
//   mem_ready    memory accepted/completed the access this cycle
//   mem_req      memory access request
//   mem_read     access is a read
//   mem_write    access is a write
//   iord         address select: 0 = PC, 1 = ALUOut
//   ir_write     load instruction register
//   pc_en        PC load enable
//   pc_src       00 = ALU result, 01 = ALUOut, 10 = jump target
//   alu_src_a    0 = PC, 1 = register A
//   alu_src_b    00 = B, 01 = 1, 10 = sext imm, 11 = sext imm << 2
//   alu_op       00 = add, 01 = sub, 10 = funct field
//   reg_dst      1 = rd, 0 = rt
//   memto_reg    1 = MDR, 0 = ALUOut
//   reg_write    register file write enable
//   illegal_op   one-cycle pulse on an unsupported opcode
//   bus_err      one-cycle pulse on a memory timeout
//   state        current state (debug)
//   cycle_cnt    free-running cycle counter
//   retired_cnt  completed-instruction counter
// -----------------------------------------------------------------------------
module mips_multicycle_ctrl #(
   parameter int unsigned MEM_TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [5:0]  opcode,
   input  logic        zero,
   input  logic        mem_ready,
   output logic        mem_req,
   output logic        mem_read,
   output logic        mem_write,
   output logic        iord,
   output logic        ir_write,
   output logic        pc_en,
   output logic [1:0]  pc_src,
   output logic        alu_src_a,
   output logic [1:0]  alu_src_b,
   output logic [1:0]  alu_op,
   output logic        reg_dst,
   output logic        memto_reg,
   output logic        reg_write,
   output logic        illegal_op,
   output logic        bus_err,
   output logic [3:0]  state,
   output logic [31:0] cycle_cnt,
   output logic [31:0] retired_cnt
);

   // State encoding is visible on the debug port, so the codes are fixed.
   localparam logic [3:0] S_FETCH  = 4'd0;
   localparam logic [3:0] S_DECODE = 4'd1;
   localparam logic [3:0] S_MEMADR = 4'd2;
   localparam logic [3:0] S_MEMRD  = 4'd3;
   localparam logic [3:0] S_MEMWB  = 4'd4;
   localparam logic [3:0] S_MEMWR  = 4'd5;
   localparam logic [3:0] S_EXEC   = 4'd6;
   localparam logic [3:0] S_ALUWB  = 4'd7;
   localparam logic [3:0] S_BRANCH = 4'd8;
   localparam logic [3:0] S_JUMP   = 4'd9;
   localparam logic [3:0] S_ADDIEX = 4'd10;
   localparam logic [3:0] S_ADDIWB = 4'd11;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   localparam logic [7:0] WAIT_LIMIT = 8'(MEM_TIMEOUT - 1);

   generate
      if (MEM_TIMEOUT < 2 || MEM_TIMEOUT > 255) begin : g_bad_timeout
         $error("MEM_TIMEOUT must be in 2..255");
      end
   endgenerate

   logic [3:0] next_state;
   logic [7:0] wait_cnt;
   logic       mem_state;
   logic       timeout;
   logic       retire;

   // States that wait on the memory handshake; mem_ready is ignored elsewhere.
   assign mem_state = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);

   // A ready arriving on the limit cycle wins over the timeout.
   assign timeout = mem_state && !mem_ready && (wait_cnt == WAIT_LIMIT);

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every variable gets a default first so no path infers a latch.
      next_state = state;
      illegal_op = 1'b0;
      case (state)
         S_FETCH: begin
            if (mem_ready)    next_state = S_DECODE;
            else if (timeout) next_state = S_FETCH;   // re-fetch the same PC
         end
         S_DECODE: begin
            case (opcode)
               OP_RTYPE:       next_state = S_EXEC;
               OP_LW, OP_SW:   next_state = S_MEMADR;
               OP_BEQ:         next_state = S_BRANCH;
               OP_J:           next_state = S_JUMP;
               OP_ADDI:        next_state = S_ADDIEX;
               default: begin
                  next_state = S_FETCH;
                  illegal_op = 1'b1;
               end
            endcase
         end
         S_MEMADR: begin
            // Opcode is held from the IR, so only lw/sw can reach here.
            if (opcode == OP_LW)      next_state = S_MEMRD;
            else if (opcode == OP_SW) next_state = S_MEMWR;
            else                      next_state = S_FETCH;
         end
         S_MEMRD: begin
            if (mem_ready)    next_state = S_MEMWB;
            else if (timeout) next_state = S_FETCH;
         end
         S_MEMWB:  next_state = S_FETCH;
         S_MEMWR: begin
            if (mem_ready || timeout) next_state = S_FETCH;
         end
         S_EXEC:   next_state = S_ALUWB;
         S_ALUWB:  next_state = S_FETCH;
         S_BRANCH: next_state = S_FETCH;
         S_JUMP:   next_state = S_FETCH;
         S_ADDIEX: next_state = S_ADDIWB;
         S_ADDIWB: next_state = S_FETCH;
         default:  next_state = S_FETCH;             // codes 12..15 recover
      endcase
   end

   // Completed instructions only; illegal-opcode and timeout exits do not count.
   always_comb begin
      retire = 1'b0;
      case (state)
         S_MEMWB, S_ALUWB, S_BRANCH, S_JUMP, S_ADDIWB: retire = 1'b1;
         S_MEMWR: retire = mem_ready;
         default: retire = 1'b0;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Moore output decode (pc_en and ir_write additionally gated by zero/ready)
   // ---------------------------------------------------------------------------
   always_comb begin
      mem_req   = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      iord      = 1'b0;
      ir_write  = 1'b0;
      pc_en     = 1'b0;
      pc_src    = 2'b00;
      alu_src_a = 1'b0;
      alu_src_b = 2'b00;
      alu_op    = 2'b00;
      reg_dst   = 1'b0;
      memto_reg = 1'b0;
      reg_write = 1'b0;
      case (state)
         S_FETCH: begin
            mem_req   = 1'b1;
            mem_read  = 1'b1;
            alu_src_b = 2'b01;             // PC + 1
            ir_write  = mem_ready;
            pc_en     = mem_ready;
         end
         S_DECODE: begin
            alu_src_b = 2'b11;             // precompute branch target
         end
         S_MEMADR, S_ADDIEX: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
         end
         S_MEMRD: begin
            mem_req  = 1'b1;
            mem_read = 1'b1;
            iord     = 1'b1;
         end
         S_MEMWB: begin
            reg_write = 1'b1;
            memto_reg = 1'b1;
         end
         S_MEMWR: begin
            mem_req   = 1'b1;
            mem_write = 1'b1;
            iord      = 1'b1;
         end
         S_EXEC: begin
            alu_src_a = 1'b1;
            alu_op    = 2'b10;
         end
         S_ALUWB: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
         end
         S_BRANCH: begin
            alu_src_a = 1'b1;
            alu_op    = 2'b01;
            pc_src    = 2'b01;
            pc_en     = zero;
         end
         S_JUMP: begin
            pc_src = 2'b10;
            pc_en  = 1'b1;
         end
         S_ADDIWB: begin
            reg_write = 1'b1;
         end
         default: ;
      endcase
   end

   assign bus_err = timeout;

   // ---------------------------------------------------------------------------
   // State, wait counter and performance counters
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= S_FETCH;
         wait_cnt    <= 8'd0;
         cycle_cnt   <= 32'd0;
         retired_cnt <= 32'd0;
      end else begin
         // NOTE: non-blocking assignments keep all registers updating from
         // the same pre-edge values.
         state     <= next_state;
         cycle_cnt <= cycle_cnt + 32'd1;
         if (retire && next_state == S_FETCH) retired_cnt <= retired_cnt + 32'd1;
         // Counting only while stalled in a memory state means any state
         // change or ready leaves the counter at zero for the next access.
         if (mem_state && !mem_ready && !timeout) wait_cnt <= wait_cnt + 8'd1;
         else                                     wait_cnt <= 8'd0;
      end
   end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mips_multicycle_ctrl
//
// Self-checking bench for mips_multicycle_ctrl. A behavioural model expands
// each opcode into its list of phases, walks them cycle by cycle with the
// chosen memory wait pattern, and predicts outputs, state and both counters.
// -----------------------------------------------------------------------------
module tb_mips_multicycle_ctrl;

   localparam int TMO = 4;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   typedef enum logic [3:0] {
      P_FETCH = 4'd0, P_DECODE = 4'd1, P_MEMADR = 4'd2, P_MEMRD = 4'd3,
      P_MEMWB = 4'd4, P_MEMWR = 4'd5, P_EXEC = 4'd6, P_ALUWB = 4'd7,
      P_BRANCH = 4'd8, P_JUMP = 4'd9, P_ADDIEX = 4'd10, P_ADDIWB = 4'd11
   } phase_e;

   typedef struct packed {
      logic       mem_req;
      logic       mem_read;
      logic       mem_write;
      logic       iord;
      logic       ir_write;
      logic       pc_en;
      logic [1:0] pc_src;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic       reg_dst;
      logic       memto_reg;
      logic       reg_write;
      logic       illegal_op;
      logic       bus_err;
   } ctrl_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [5:0]  opcode;
   logic        zero;
   logic        mem_ready;
   logic        mem_req, mem_read, mem_write, iord, ir_write, pc_en;
   logic [1:0]  pc_src;
   logic        alu_src_a;
   logic [1:0]  alu_src_b, alu_op;
   logic        reg_dst, memto_reg, reg_write, illegal_op, bus_err;
   logic [3:0]  state;
   logic [31:0] cycle_cnt, retired_cnt;

   ctrl_t act;
   assign act = {mem_req, mem_read, mem_write, iord, ir_write, pc_en, pc_src,
                 alu_src_a, alu_src_b, alu_op, reg_dst, memto_reg, reg_write,
                 illegal_op, bus_err};

   int          checks = 0;
   int          fails  = 0;
   logic [31:0] exp_cycles  = '0;
   logic [31:0] exp_retired = '0;
   int          rw_pulses = 0;

   always #5 clk = ~clk;

   always @(negedge clk) if (reg_write === 1'b1) rw_pulses++;

   mips_multicycle_ctrl #(.MEM_TIMEOUT(TMO)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
      .mem_ready(mem_ready), .mem_req(mem_req), .mem_read(mem_read),
      .mem_write(mem_write), .iord(iord), .ir_write(ir_write), .pc_en(pc_en),
      .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .alu_op(alu_op), .reg_dst(reg_dst), .memto_reg(memto_reg),
      .reg_write(reg_write), .illegal_op(illegal_op), .bus_err(bus_err),
      .state(state), .cycle_cnt(cycle_cnt), .retired_cnt(retired_cnt)
   );

   // ---------------------------------------------------------------------------
   // Reference model
   // ---------------------------------------------------------------------------
   function automatic bit is_legal(input logic [5:0] op);
      return op inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};
   endfunction

   function automatic ctrl_t expect_ctrl(input phase_e p, input logic rdy,
                                         input logic z, input logic bad,
                                         input logic tmo);
      ctrl_t e;
      e = '0;
      case (p)
         P_FETCH:  begin e.mem_req = 1; e.mem_read = 1; e.alu_src_b = 2'b01;
                         e.ir_write = rdy; e.pc_en = rdy; e.bus_err = tmo; end
         P_DECODE: begin e.alu_src_b = 2'b11; e.illegal_op = bad; end
         P_MEMADR: begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
         P_MEMRD:  begin e.mem_req = 1; e.mem_read = 1; e.iord = 1; e.bus_err = tmo; end
         P_MEMWB:  begin e.reg_write = 1; e.memto_reg = 1; end
         P_MEMWR:  begin e.mem_req = 1; e.mem_write = 1; e.iord = 1; e.bus_err = tmo; end
         P_EXEC:   begin e.alu_src_a = 1; e.alu_op = 2'b10; end
         P_ALUWB:  begin e.reg_write = 1; e.reg_dst = 1; end
         P_BRANCH: begin e.alu_src_a = 1; e.alu_op = 2'b01; e.pc_src = 2'b01; e.pc_en = z; end
         P_JUMP:   begin e.pc_src = 2'b10; e.pc_en = 1; end
         P_ADDIEX: begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
         P_ADDIWB: begin e.reg_write = 1; end
         default: ;
      endcase
      return e;
   endfunction

   // One clock cycle spent in phase p: drive, compare, advance.
   task automatic do_cycle(input phase_e p, input logic [5:0] op, input logic rdy,
                           input logic z, input logic tmo, input logic bad,
                           input bit retire);
      ctrl_t exp;
      opcode    = (p == P_FETCH) ? 6'($urandom) : op;   // IR not yet loaded
      mem_ready = rdy;
      zero      = z;
      #1;
      exp = expect_ctrl(p, rdy, z, bad, tmo);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL ctrl_vec phase=%0d got=%b expected=%b", p, act, exp);
      end
      checks++;
      if (state !== 4'(p)) begin
         fails++;
         $display("FAIL state got=%0d expected=%0d", state, p);
      end
      checks++;
      if (cycle_cnt !== exp_cycles) begin
         fails++;
         $display("FAIL cycle_cnt got=%0d expected=%0d", cycle_cnt, exp_cycles);
      end
      checks++;
      if (retired_cnt !== exp_retired) begin
         fails++;
         $display("FAIL retired_cnt got=%0d expected=%0d", retired_cnt, exp_retired);
      end
      @(posedge clk);
      #1;
      exp_cycles++;
      if (retire) exp_retired++;
   endtask

   // Walk one instruction. fw/mw: wait cycles before ready in fetch / data
   // access; a value >= TMO means ready never comes and the access times out.
   task automatic run_instr(input logic [5:0] op, input logic z, input int fw,
                            input int mw, output bit done);
      phase_e seq[$];
      bit     bad;
      bad  = !is_legal(op);
      done = 0;
      seq  = '{P_FETCH, P_DECODE};
      case (op)
         OP_RTYPE: begin seq.push_back(P_EXEC);   seq.push_back(P_ALUWB); end
         OP_LW:    begin seq.push_back(P_MEMADR); seq.push_back(P_MEMRD);
                         seq.push_back(P_MEMWB); end
         OP_SW:    begin seq.push_back(P_MEMADR); seq.push_back(P_MEMWR); end
         OP_BEQ:   seq.push_back(P_BRANCH);
         OP_J:     seq.push_back(P_JUMP);
         OP_ADDI:  begin seq.push_back(P_ADDIEX); seq.push_back(P_ADDIWB); end
         default: ;
      endcase
      for (int i = 0; i < seq.size(); i++) begin
         phase_e p;
         bit     last;
         p    = seq[i];
         last = (i == seq.size() - 1);
         if (p inside {P_FETCH, P_MEMRD, P_MEMWR}) begin
            int   w;
            bit   tmo;
            logic rdy;
            w   = (p == P_FETCH) ? fw : mw;
            tmo = 0;
            for (int c = 0; c < TMO; c++) begin
               rdy = (c >= w);
               tmo = !rdy && (c == TMO - 1);
               do_cycle(p, op, rdy, 1'($urandom), tmo, bad, last && rdy && !bad);
               if (rdy || tmo) break;
            end
            if (tmo) return;
         end else begin
            do_cycle(p, op, 1'($urandom), (p == P_BRANCH) ? z : 1'($urandom),
                     1'b0, bad, last && !bad);
         end
      end
      done = !bad;
   endtask

   task automatic expect_fetch(input string name);
      checks++;
      if (state !== 4'd0) begin
         fails++;
         $display("FAIL %s state got=%0d expected=0", name, state);
      end
   endtask

   // Latency measured from the DUT's own cycle counter and retired delta.
   task automatic timed_instr(input string name, input logic [5:0] op, input logic z,
                              input int fw, input int mw, input int exp_lat,
                              input int exp_ret);
      logic [31:0] c0, r0;
      bit          done;
      c0 = cycle_cnt;
      r0 = retired_cnt;
      run_instr(op, z, fw, mw, done);
      checks++;
      if (cycle_cnt - c0 !== 32'(exp_lat)) begin
         fails++;
         $display("FAIL %s latency got=%0d expected=%0d", name, cycle_cnt - c0, exp_lat);
      end
      checks++;
      if (retired_cnt - r0 !== 32'(exp_ret)) begin
         fails++;
         $display("FAIL %s retired_delta got=%0d expected=%0d", name,
                  retired_cnt - r0, exp_ret);
      end
      expect_fetch(name);
   endtask

   // ---------------------------------------------------------------------------
   // Scenarios
   // ---------------------------------------------------------------------------
   task automatic test_reset();
      do_cycle(P_FETCH, OP_RTYPE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      do_cycle(P_DECODE, OP_RTYPE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      // now in EXEC: assert reset between edges
      mem_ready = 1'b0;
      reset     = 1'b0;
      #1;
      checks++;
      if (state !== 4'd0 || mem_req !== 1'b1 || mem_read !== 1'b1) begin
         fails++;
         $display("FAIL reset_async state=%0d mem_req=%b mem_read=%b expected 0/1/1",
                  state, mem_req, mem_read);
      end
      checks++;
      if (cycle_cnt !== 32'd0 || retired_cnt !== 32'd0) begin
         fails++;
         $display("FAIL reset_counters cycle=%0d retired=%0d expected 0/0",
                  cycle_cnt, retired_cnt);
      end
      checks++;
      if (pc_en !== 1'b0 || ir_write !== 1'b0 || reg_write !== 1'b0 ||
          illegal_op !== 1'b0 || bus_err !== 1'b0) begin
         fails++;
         $display("FAIL reset_idle_outs got=%b expected pc_en/ir_write/reg_write/illegal/bus_err all 0",
                  {pc_en, ir_write, reg_write, illegal_op, bus_err});
      end
      mem_ready = 1'b1;
      #1;
      checks++;
      if (pc_en !== 1'b1 || ir_write !== 1'b1) begin
         fails++;
         $display("FAIL reset_ready_outs pc_en=%b ir_write=%b expected 1/1", pc_en, ir_write);
      end
      mem_ready = 1'b0;
      @(posedge clk);
      #1;
      reset       = 1'b1;
      exp_cycles  = '0;
      exp_retired = '0;
      do_cycle(P_FETCH, OP_RTYPE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      expect_fetch("reset_first_edge");
   endtask

   task automatic test_zero_wait_mix();
      logic [31:0] c0, r0;
      logic [5:0]  ops [6];
      int          lats [6];
      ops  = '{OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};
      lats = '{4, 5, 4, 3, 3, 4};
      c0 = cycle_cnt;
      r0 = retired_cnt;
      for (int i = 0; i < 6; i++)
         timed_instr("mix", ops[i], 1'($urandom), 0, 0, lats[i], 1);
      checks++;
      if (cycle_cnt - c0 !== 32'd23 || retired_cnt - r0 !== 32'd6) begin
         fails++;
         $display("FAIL mix_total cycles=%0d retired=%0d expected 23/6",
                  cycle_cnt - c0, retired_cnt - r0);
      end
   endtask

   task automatic test_beq();
      timed_instr("beq_taken",     OP_BEQ, 1'b1, 0, 0, 3, 1);
      timed_instr("beq_not_taken", OP_BEQ, 1'b0, 0, 0, 3, 1);
   endtask

   task automatic test_wait_states();
      rw_pulses = 0;
      timed_instr("lw_wait3", OP_LW, 1'b0, 0, 3, 8, 1);
      checks++;
      if (rw_pulses !== 1) begin
         fails++;
         $display("FAIL lw_wait3 reg_write_pulses got=%0d expected=1", rw_pulses);
      end
   endtask

   task automatic test_timeout();
      timed_instr("sw_timeout",      OP_SW,    1'b0, 0, TMO, 7, 0);
      timed_instr("sw_ready_at_lim", OP_SW,    1'b0, 0, TMO - 1, 7, 1);
      timed_instr("fetch_timeout",   OP_RTYPE, 1'b0, TMO, 0, TMO, 0);
      timed_instr("lw_timeout",      OP_LW,    1'b0, 1, TMO, 8, 0);
   endtask

   task automatic test_illegal();
      timed_instr("illegal_3f", 6'b111111, 1'b0, 0, 0, 2, 0);
      timed_instr("illegal_01", 6'b000001, 1'b0, 1, 0, 3, 0);
   endtask

   task automatic test_random();
      logic [5:0] legal [6];
      logic [5:0] op;
      bit         done;
      legal = '{OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};
      for (int n = 0; n < 200; n++) begin
         if ($urandom_range(0, 9) == 0) op = 6'($urandom);
         else                           op = legal[$urandom_range(0, 5)];
         run_instr(op, 1'($urandom),
                   ($urandom_range(0, 7) == 0) ? TMO : int'($urandom_range(0, TMO - 1)),
                   ($urandom_range(0, 7) == 0) ? TMO : int'($urandom_range(0, TMO - 1)),
                   done);
      end
      expect_fetch("random_end");
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 3; i++) begin
         timed_instr("b2b_j",    OP_J,    1'b0, 0, 0, 3, 1);
         timed_instr("b2b_addi", OP_ADDI, 1'b0, 0, 0, 4, 1);
      end
   endtask

   initial begin
      reset     = 1'b0;
      mem_ready = 1'b0;
      zero      = 1'b0;
      opcode    = 6'd0;
      repeat (3) @(posedge clk);
      #1;
      reset       = 1'b1;
      exp_cycles  = '0;
      exp_retired = '0;

      test_reset();
      test_zero_wait_mix();
      test_beq();
      test_wait_states();
      test_timeout();
      test_illegal();
      test_back_to_back();
      test_random();

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
